// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NUM_REQ valid/ready producers, bounded bursts.
// Define FIFO_ARB_FIXED_PRIO_EN to select fixed priority (lowest valid index wins) instead of round-robin.
module fifo_push_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BIT_WIDTH = 8,
  parameter int BURST     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic                         fifo_push,
  output logic [BIT_WIDTH-1:0]         fifo_push_data,
  input  logic                         fifo_full
);

  // state | meaning
  // IDLE  | no owner; a winner is picked whenever any req_valid is high
  // GRANT | grant[owner] holds the push port until burst end or valid drop

  localparam int CNT_W = $clog2(BURST + 1);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [IDX_W-1:0]   last, last_nxt, owner, winner;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               owner_valid;

  always_comb begin
    owner          = '0;
    fifo_push_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        owner          = IDX_W'(i);
        fifo_push_data = req_data[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  assign busy        = (state == GRANT);
  assign owner_valid = |(req_valid & grant);
  assign req_ready   = fifo_full ? '0 : grant;
  assign fifo_push   = busy & owner_valid & ~fifo_full;

  always_comb begin : win_sel
`ifdef FIFO_ARB_FIXED_PRIO_EN
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) winner = IDX_W'(i);
    end
`else
    logic [IDX_W-1:0] cand;
    logic             found;
    winner = '0;
    found  = 1'b0;
    // search starts just after the previous owner and wraps
    cand   = (last == IDX_W'(NUM_REQ - 1)) ? '0 : last + IDX_W'(1);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + IDX_W'(1);
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt = GRANT;
          grant_nxt = NUM_REQ'(1) << winner;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        // a valid drop releases even if the FIFO is full the same cycle
        if (!owner_valid || (fifo_push && cnt == CNT_W'(BURST - 1))) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          last_nxt  = owner;
        end else if (fifo_push) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= IDX_W'(NUM_REQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: reset, single/all requesters, full stall, early release, priority order.
module tb_fifo_push_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int B = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           fifo_push;
  logic [W-1:0]   fifo_push_data;
  logic           fifo_full;

  fifo_push_arbiter #(.NUM_REQ(N), .BIT_WIDTH(W), .BURST(B)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .busy(busy), .fifo_push(fifo_push),
    .fifo_push_data(fifo_push_data), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         len[N];
  int         sent[N];
  int         exp_idx[N];
  logic [W-1:0] base[N];
  logic [W-1:0] log_q[$];
  int         order[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // producers present word base+sent until accepted, dropping valid once len words are sent
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = (sent[i] < len[i]);
      req_data[i*W +: W]  = base[i] + 8'(sent[i]);
    end
  endtask

  task automatic cycle(input logic full);
    logic [N-1:0] acc;
    acc = req_valid & req_ready;
    if (fifo_push) log_q.push_back(fifo_push_data);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) sent[i]++;
    fifo_full = full;
    drive();
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      len[i] = 0; sent[i] = 0; exp_idx[i] = 0; base[i] = '0;
    end
    fifo_full = 1'b0;
    drive();
    log_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  // expects an IDLE cycle now, then n consecutive pushes from requester g
  task automatic expect_burst(input int g, input int n);
    check("idle_busy", busy, 0);
    check("idle_grant", grant, 0);
    for (int k = 0; k < n; k++) begin
      cycle(1'b0);
      check("grant", grant, 32'(1) << g);
      check("busy", busy, 1);
      check("ready", req_ready, 32'(1) << g);
      check("push", fifo_push, 1);
      check("data", fifo_push_data, base[g] + 8'(exp_idx[g]));
      exp_idx[g]++;
    end
  endtask

  initial begin
    rst = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      len[i] = 1; sent[i] = 0; exp_idx[i] = 0; base[i] = 8'h11;
    end
    drive();
    #3;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_push", fifo_push, 0);
    check("rst_data", fifo_push_data, 0);
    apply_reset();

    // single requester, 6 words: 4-word burst, idle, 2-word burst, valid-drop release
    base[0] = 8'hA0; len[0] = 6; drive(); #1;
    expect_burst(0, 4);
    cycle(1'b0);
    expect_burst(0, 2);
    cycle(1'b0);
    check("drop_busy", busy, 1);
    check("drop_grant", grant, 4'b0001);
    check("drop_push", fifo_push, 0);
    cycle(1'b0);
    check("drop_idle", busy, 0);
    check("single_cnt", log_q.size(), 6);
    for (int k = 0; k < log_q.size() && k < 6; k++) check("single_log", log_q[k], 8'hA0 + 8'(k));

    // requester 1 granted next (round-robin after 0), then reset mid-burst
    base[1] = 8'hB0; len[1] = 10; drive(); #1;
    expect_burst(1, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_push", fifo_push, 0);
    check("mid_rst_data", fifo_push_data, 0);
    apply_reset();

    // all four valid: order 0,1,2,3,0 with an idle cycle between grants
    for (int i = 0; i < N; i++) begin
      base[i] = 8'(8'h10 * (i + 1)); len[i] = 8;
    end
    drive(); #1;
    expect_burst(0, 4); cycle(1'b0);
    expect_burst(1, 4); cycle(1'b0);
    expect_burst(2, 4); cycle(1'b0);
    expect_burst(3, 4); cycle(1'b0);
    expect_burst(0, 4); cycle(1'b0);
    check("rr_cnt", log_q.size(), 20);
    if (log_q.size() == 20) begin
      check("rr_log5", log_q[4], 8'h20);
      check("rr_log17", log_q[16], 8'h14);
    end
    apply_reset();

    // full stall for 3 cycles after the 2nd word
    base[0] = 8'h50; len[0] = 4; drive(); #1;
    expect_burst(0, 2);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1);
      check("stall_ready", req_ready, 0);
      check("stall_push", fifo_push, 0);
      check("stall_grant", grant, 4'b0001);
    end
    cycle(1'b0);
    check("stall_push2", fifo_push, 1);
    check("stall_data2", fifo_push_data, 8'h52);
    cycle(1'b0);
    check("stall_push3", fifo_push, 1);
    check("stall_data3", fifo_push_data, 8'h53);
    cycle(1'b0);
    check("stall_idle", busy, 0);
    check("stall_cnt", log_q.size(), 4);
    for (int k = 0; k < log_q.size() && k < 4; k++) check("stall_log", log_q[k], 8'h50 + 8'(k));
    log_q.delete();

    // early release: requester 2 sends 2 words then drops valid, requester 3 follows
    base[2] = 8'h60; len[2] = 2; base[3] = 8'h70; len[3] = 2; drive(); #1;
    expect_burst(2, 2);
    cycle(1'b0);
    check("early_busy", busy, 1);
    check("early_push", fifo_push, 0);
    cycle(1'b0);
    expect_burst(3, 2);
    cycle(1'b0);
    check("early_push3", fifo_push, 0);
    cycle(1'b0);
    check("early_idle", busy, 0);
    apply_reset();

    // requesters 0 and 2 continuously valid
`ifdef FIFO_ARB_FIXED_PRIO_EN
    order[0] = 0; order[1] = 0; order[2] = 2;
`else
    order[0] = 0; order[1] = 2; order[2] = 0;
`endif
    base[0] = 8'h80; len[0] = 8; base[2] = 8'h90; len[2] = 4; drive(); #1;
    for (int j = 0; j < 3; j++) begin
      expect_burst(order[j], 4);
      cycle(1'b0);
    end
    check("prio_idle", busy, 0);
    check("prio_cnt", log_q.size(), 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
